// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load extractor.
// Latency: n/a (types only).
// Backpressure: n/a.
package wb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_PC4  = 2'd2,
        SRC_IMM  = 2'd3
    } wb_src_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle between control FSM / memory / register file and the writeback stage; trap exists only with WB_MISALIGN_TRAP_EN.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready handshake; mem_rvalid is a pulse with no ready.
interface writeback_stage_if;

    logic                     req_valid;
    logic                     req_ready;
    logic [4:0]               req_rd;
    logic [1:0]               req_src;
    logic [2:0]               req_funct3;
    logic [1:0]               req_addr_lo;
    logic [wb_pkg::XLEN-1:0]  alu_result;
    logic [wb_pkg::XLEN-1:0]  pc_plus4;
    logic [wb_pkg::XLEN-1:0]  imm;
    logic                     mem_rvalid;
    logic [wb_pkg::XLEN-1:0]  mem_rdata;
    logic [4:0]               wr_addr;
    logic [wb_pkg::XLEN-1:0]  wr_data;
    logic                     wr_en;
    logic                     done;
`ifdef WB_MISALIGN_TRAP_EN
    logic                     trap;
`endif

    modport master (
        output req_valid, req_rd, req_src, req_funct3, req_addr_lo,
        output alu_result, pc_plus4, imm, mem_rvalid, mem_rdata,
`ifdef WB_MISALIGN_TRAP_EN
        input  trap,
`endif
        input  req_ready, wr_addr, wr_data, wr_en, done
    );

    modport slave (
        input  req_valid, req_rd, req_src, req_funct3, req_addr_lo,
        input  alu_result, pc_plus4, imm, mem_rvalid, mem_rdata,
`ifdef WB_MISALIGN_TRAP_EN
        output trap,
`endif
        output req_ready, wr_addr, wr_data, wr_en, done
    );

endinterface

// File: rtl/load_extract.sv
// Selects the byte/half/word of an aligned memory word by funct3 and extends it.
// Latency: combinational.
// Backpressure: none.
module load_extract
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (addr_lo)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
    end

    // Halfword uses only addr_lo[1]; an odd offset falls back to the enclosing half.
    assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext_data = mem_rdata;
        case (funct3)
            F3_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  ext_data = {24'd0, byte_sel};
            F3_LHU:  ext_data = {16'd0, half_sel};
            default: ext_data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: picks ALU/LOAD/PC4/IMM result and issues one register-file write; WB_MISALIGN_TRAP_EN adds load-fault trap.
// Latency: non-load 1 cycle after accept; load 1 cycle after mem_rvalid.
// Backpressure: req_ready only in IDLE; stray mem_rvalid and busy-time req_valid are dropped.
module writeback_stage
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    writeback_stage_if.slave bus
);

    wb_state_e       state_q, state_d;
    wb_src_e         src;
    logic            accept;
    logic            is_load;
    logic            load_fault;
    logic [4:0]      rd_q;
    logic [2:0]      funct3_q;
    logic [1:0]      addr_lo_q;
    logic            trap_q;
    logic [4:0]      wr_addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic [XLEN-1:0] sel_val;
    logic [XLEN-1:0] ext_data;

    assign src     = wb_src_e'(bus.req_src);
    assign accept  = (state_q == ST_IDLE) && bus.req_valid;
    assign is_load = (src == SRC_LOAD);

`ifdef WB_MISALIGN_TRAP_EN
    always_comb begin
        load_fault = 1'b0;
        if (is_load) begin
            case (bus.req_funct3)
                F3_LB, F3_LBU: load_fault = 1'b0;
                F3_LH, F3_LHU: load_fault = bus.req_addr_lo[0];
                F3_LW:         load_fault = (bus.req_addr_lo != 2'b00);
                default:       load_fault = 1'b1;
            endcase
        end
    end
`else
    assign load_fault = 1'b0;
`endif

    always_comb begin
        sel_val = bus.alu_result;
        case (src)
            SRC_PC4: sel_val = bus.pc_plus4;
            SRC_IMM: sel_val = bus.imm;
            default: sel_val = bus.alu_result;
        endcase
    end

    load_extract u_load_extract (
        .mem_rdata (bus.mem_rdata),
        .funct3    (funct3_q),
        .addr_lo   (addr_lo_q),
        .ext_data  (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.req_valid) state_d = (is_load && !load_fault) ? ST_WAIT_MEM : ST_WRITE;
            ST_WAIT_MEM: if (bus.mem_rvalid) state_d = ST_WRITE;
            ST_WRITE:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // wr_addr/wr_data only move when a real write is about to happen, so they hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q      <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            trap_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (accept) begin
            rd_q      <= bus.req_rd;
            funct3_q  <= bus.req_funct3;
            addr_lo_q <= bus.req_addr_lo;
            trap_q    <= load_fault;
            if (!is_load && (bus.req_rd != 5'd0)) begin
                wr_addr_q <= bus.req_rd;
                wr_data_q <= sel_val;
            end
        end else if ((state_q == ST_WAIT_MEM) && bus.mem_rvalid && (rd_q != 5'd0)) begin
            wr_addr_q <= rd_q;
            wr_data_q <= ext_data;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.done      = (state_q == ST_WRITE);
    assign bus.wr_en     = (state_q == ST_WRITE) && (rd_q != 5'd0) && !trap_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
`ifdef WB_MISALIGN_TRAP_EN
    assign bus.trap      = (state_q == ST_WRITE) && trap_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: scoreboard of expected retirements checked on done.
module tb_writeback_stage;
    import wb_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        en;
        logic        trap;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc = 0;
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];
    exp_t mon_e;

    writeback_stage_if bus();

    writeback_stage dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", cmp_cnt);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Retirement monitor: every done must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.wr_en === 1'b1) check("wr_en_implies_done", 32'(bus.done), 32'd1);
            if (bus.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("wr_en", 32'(bus.wr_en), 32'(mon_e.en));
                    if (mon_e.en) begin
                        check("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
                        check("wr_data", bus.wr_data, mon_e.data);
                    end
`ifdef WB_MISALIGN_TRAP_EN
                    check("trap", 32'(bus.trap), 32'(mon_e.trap));
`endif
                end
            end
        end
    end

    task automatic send(input logic [1:0] src, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] val, input logic exp_trap,
                        output int acc);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_ready_before_send", 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.req_src     = src;
        bus.req_rd      = rd;
        bus.req_funct3  = f3;
        bus.req_addr_lo = alo;
        bus.alu_result  = (src == SRC_ALU) ? val : ~val;
        bus.pc_plus4    = (src == SRC_PC4) ? val : ~val;
        bus.imm         = (src == SRC_IMM) ? val : ~val;
        acc = cyc;
        if (src != SRC_LOAD || exp_trap)
            sb.push_back('{addr: rd, data: val, en: (rd != 5'd0) && !exp_trap, trap: exp_trap, cyc: cyc + 1});
        tick();
        bus.req_valid  = 1'b0;
        bus.alu_result = 32'h0BAD_0001;
        bus.pc_plus4   = 32'h0BAD_0002;
        bus.imm        = 32'h0BAD_0003;
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                           input logic [31:0] rdata, input int dly, input logic [31:0] exp_d);
        int acc;
        send(SRC_LOAD, rd, f3, alo, 32'd0, 1'b0, acc);
        for (int i = 1; i < dly; i++) begin
            check("wait_mem_not_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        sb.push_back('{addr: rd, data: exp_d, en: (rd != 5'd0), trap: 1'b0, cyc: cyc + 1});
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'hA5A5_5A5A;
        drain();
    endtask

    initial begin
        int a1, a2;
        reset_n         = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_rd      = '0;
        bus.req_src     = '0;
        bus.req_funct3  = '0;
        bus.req_addr_lo = '0;
        bus.alu_result  = '0;
        bus.pc_plus4    = '0;
        bus.imm         = '0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = 32'hA5A5_5A5A;

        repeat (3) tick();
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        reset_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);

        // ALU write, exactly one cycle after accept; not ready in the WRITE cycle.
        send(SRC_ALU, 5'd5, 3'd0, 2'd0, 32'hDEAD_BEEF, 1'b0, a1);
        check("write_cycle_not_ready", 32'(bus.req_ready), 32'd0);
        drain();

        // Back-to-back non-loads: 2-cycle throughput.
        send(SRC_ALU, 5'd1, 3'd0, 2'd0, 32'h1111_1111, 1'b0, a1);
        send(SRC_IMM, 5'd2, 3'd0, 2'd0, 32'h0000_0022, 1'b0, a2);
        check("throughput", 32'(a2 - a1), 32'd2);
        drain();

        do_load(5'd3, F3_LB,  2'd2, 32'h1280_FF34, 3, 32'hFFFF_FF80);
        do_load(5'd4, F3_LBU, 2'd2, 32'h1280_FF34, 3, 32'h0000_0080);
        do_load(5'd6, F3_LHU, 2'd2, 32'h8001_1234, 2, 32'h0000_8001);

        // rd==0: retires without writing; write port keeps the LHU result.
        send(SRC_PC4, 5'd0, 3'd0, 2'd0, 32'h0000_1004, 1'b0, a1);
        drain();
        check("hold_wr_addr", 32'(bus.wr_addr), 32'd6);
        check("hold_wr_data", bus.wr_data, 32'h0000_8001);

        // Minimum-latency loads across byte/half/word selections.
        do_load(5'd10, F3_LB,  2'd0, 32'h1280_FF34, 1, 32'h0000_0034);
        do_load(5'd11, F3_LB,  2'd3, 32'h1280_FF34, 1, 32'h0000_0012);
        do_load(5'd12, F3_LBU, 2'd1, 32'h1280_FF34, 1, 32'h0000_00FF);
        do_load(5'd13, F3_LH,  2'd0, 32'h1280_FF34, 1, 32'hFFFF_FF34);
        do_load(5'd14, F3_LH,  2'd2, 32'h8001_1234, 1, 32'hFFFF_8001);
        do_load(5'd15, F3_LW,  2'd0, 32'h1280_FF34, 1, 32'h1280_FF34);
`ifndef WB_MISALIGN_TRAP_EN
        do_load(5'd16, F3_LH,  2'd3, 32'h1280_FF34, 1, 32'h0000_1280);
        do_load(5'd17, F3_LHU, 2'd1, 32'h8001_1234, 2, 32'h0000_1234);
        do_load(5'd18, F3_LW,  2'd2, 32'h1280_FF34, 1, 32'h1280_FF34);
        do_load(5'd19, 3'b011, 2'd0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
        do_load(5'd20, 3'b110, 2'd1, 32'h8765_4321, 1, 32'h8765_4321);
`endif

        // Stray rvalid in IDLE is dropped, then an IMM write.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        tick();
        bus.mem_rvalid = 1'b0;
        check("stray_no_wr_en", 32'(bus.wr_en), 32'd0);
        check("stray_no_done", 32'(bus.done), 32'd0);
        check("stray_ready", 32'(bus.req_ready), 32'd1);
        send(SRC_IMM, 5'd9, 3'd0, 2'd0, 32'h0000_07FF, 1'b0, a1);
        drain();

        // Asynchronous reset while waiting for memory; the late rvalid must not retire.
        send(SRC_LOAD, 5'd7, F3_LB, 2'd0, 32'd0, 1'b0, a1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(bus.wr_en), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("arst_wr_data", bus.wr_data, 32'd0);
        tick();
        reset_n = 1'b1;
        check("arst_release_ready", 32'(bus.req_ready), 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1280_FF34;
        tick();
        bus.mem_rvalid = 1'b0;
        check("arst_late_rvalid_wr_en", 32'(bus.wr_en), 32'd0);
        check("arst_late_rvalid_done", 32'(bus.done), 32'd0);
        tick();
        check("arst_idle_ready", 32'(bus.req_ready), 32'd1);
        check("arst_idle_done", 32'(bus.done), 32'd0);

`ifdef WB_MISALIGN_TRAP_EN
        // Faulting loads retire the next cycle with trap and no write, never waiting on memory.
        send(SRC_LOAD, 5'd11, F3_LW, 2'd1, 32'd0, 1'b1, a1);
        drain();
        check("trap_lw_back_idle", 32'(bus.req_ready), 32'd1);
        send(SRC_LOAD, 5'd12, F3_LHU, 2'd3, 32'd0, 1'b1, a1);
        drain();
        send(SRC_LOAD, 5'd13, 3'b111, 2'd0, 32'd0, 1'b1, a1);
        drain();
        do_load(5'd14, F3_LH, 2'd2, 32'h8001_1234, 1, 32'hFFFF_8001);
`endif

        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
